// File: rtl/svn_scan.sv
// svn_scan: time-multiplexed scan controller for a 4-digit common-anode display.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module svn_scan #(
  parameter int unsigned REFRESH_DIV = 32'd100000,
  parameter int unsigned DEAD_CYCLES = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  output logic [3:0]  digit,
  output logic [3:0]  AN,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [19:0] SHOW_LAST = 20'(REFRESH_DIV - 32'd1);
  localparam logic [7:0]  GAP_LAST  = (DEAD_CYCLES > 32'd0) ? 8'(DEAD_CYCLES - 32'd1) : 8'd0;
  localparam bit          HAS_GAP   = (DEAD_CYCLES != 32'd0);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic [15:0] shv_q, shv_d;
  logic [3:0]  shb_q, shb_d;
  logic        fd_q, fd_d;
  logic        advance_s;
  logic        load_s;
  logic [3:0]  eff_blank_s;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] & (v[11:8] == 4'h0);
    m[1] = m[2] & (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

  assign eff_blank_s = blank | lz_mask(value);
`else
  assign eff_blank_s = blank;
`endif

  assign frame_done = fd_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 20'd0;
      gcnt_q  <= 8'd0;
      shv_q   <= 16'h0000;
      shb_q   <= 4'b1111;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      shv_q   <= shv_d;
      shb_q   <= shb_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state logic: scan sequencing, counters and frame-boundary shadow loads.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    fd_d      = 1'b0;
    advance_s = 1'b0;
    load_s    = (state_q == S_IDLE);

    if (!en) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      cnt_d   = 20'd0;
      gcnt_d  = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          idx_d   = 2'd0;
          cnt_d   = 20'd0;
          gcnt_d  = 8'd0;
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = 20'd0;
            if (HAS_GAP) begin
              state_d = S_GAP;
              gcnt_d  = 8'd0;
            end else begin
              advance_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
        S_GAP: begin
          if (gcnt_q == GAP_LAST) begin
            advance_s = 1'b1;
          end else begin
            gcnt_d = gcnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          cnt_d   = 20'd0;
          gcnt_d  = 8'd0;
        end
      endcase
    end

    // Leaving digit 3 closes the frame: reload shadows and flag completion.
    if (advance_s) begin
      state_d = S_SHOW;
      idx_d   = idx_q + 2'd1;
      cnt_d   = 20'd0;
      if (idx_q == 2'd3) begin
        load_s = 1'b1;
        fd_d   = 1'b1;
      end else begin
        load_s = load_s;
      end
    end else begin
      fd_d = 1'b0;
    end

    if (load_s) begin
      shv_d = value;
      shb_d = eff_blank_s;
    end else begin
      shv_d = shv_q;
      shb_d = shb_q;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    AN    = 4'b1111;
    digit = 4'hf;
    case (state_q)
      S_SHOW: begin
        if (shb_q[idx_q]) begin
          AN    = 4'b1111;
          digit = 4'hf;
        end else begin
          AN    = ~(4'b0001 << idx_q);
          digit = shv_q[{idx_q, 2'b00} +: 4];
        end
      end
      S_IDLE: begin
        AN    = 4'b1111;
        digit = 4'hf;
      end
      S_GAP: begin
        AN    = 4'b1111;
        digit = 4'hf;
      end
      default: begin
        AN    = 4'b1111;
        digit = 4'hf;
      end
    endcase
  end

endmodule

// File: tb/tb_svn_scan.sv
// Directed self-checking bench for svn_scan: one instance with a dead time of 2,
// one without, sharing value/blank/reset but with separate enables.
module tb_svn_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        en0 = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  blank = 4'b0000;
  logic [3:0]  dig1, an1, dig0, an0;
  logic        fd1, fd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svn_scan #(.REFRESH_DIV(4), .DEAD_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .blank(blank),
    .digit(dig1), .AN(an1), .frame_done(fd1)
  );

  svn_scan #(.REFRESH_DIV(4), .DEAD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .value(value), .blank(blank),
    .digit(dig0), .AN(an0), .frame_done(fd0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Walk one full frame starting on the first cycle of digit 0.
  task automatic run_frame(input bit sel, input int dead, input logic [15:0] v,
                           input logic [3:0] bl, input bit fd_first,
                           input int chg_at, input logic [15:0] vnew);
    int k;
    logic [3:0] one;
    logic [7:0] exp_s;
    logic [7:0] obs_s;
    logic       fd_exp;
    logic       fd_obs;
    k = 0;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4 + dead; c++) begin
        if (c >= 4 || bl[d]) exp_s = 8'hff;
        else exp_s = {~(one << d), v[d*4 +: 4]};
        fd_exp = (d == 0 && c == 0) ? fd_first : 1'b0;
        obs_s  = sel ? {an0, dig0} : {an1, dig1};
        fd_obs = sel ? fd0 : fd1;
        check($sformatf("scan%0d d%0d c%0d an_digit", sel, d, c), obs_s, exp_s);
        check($sformatf("scan%0d d%0d c%0d frame_done", sel, d, c), {7'd0, fd_obs}, {7'd0, fd_exp});
        if (k == chg_at) value = vnew;
        k++;
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with en high.
    rst_n = 1'b0; en = 1'b1; value = 16'h1234; blank = 4'b0000;
    #1;
    repeat (3) tick();
    check("reset an_digit", {an1, dig1}, 8'hff);
    check("reset frame_done", {7'd0, fd1}, 8'h00);
    check("reset an_digit nogap", {an0, dig0}, 8'hff);

    rst_n = 1'b1;
    tick();
    check("release first digit", {an1, dig1}, 8'he4);

    run_frame(1'b0, 2, 16'h1234, 4'b0000, 1'b0, -1, 16'h0000);
    // Value changes on digit 1 must not reach this frame.
    run_frame(1'b0, 2, 16'h1234, 4'b0000, 1'b1, 6, 16'h5678);
    run_frame(1'b0, 2, 16'h5678, 4'b0000, 1'b1, 0, 16'h5678);
    blank = 4'b0100;
    run_frame(1'b0, 2, 16'h5678, 4'b0000, 1'b1, -1, 16'h0000);
    run_frame(1'b0, 2, 16'h5678, 4'b0100, 1'b1, -1, 16'h0000);

    // Drop enable in the digit 0 gap.
    check("frame E start", {an1, dig1}, 8'he8);
    repeat (4) tick();
    check("gap before disable", {an1, dig1}, 8'hff);
    en = 1'b0;
    tick();
    check("idle after disable", {an1, dig1}, 8'hff);
    check("idle frame_done", {7'd0, fd1}, 8'h00);
    tick();
    check("idle hold", {an1, dig1}, 8'hff);
    en = 1'b1;
    tick();
    check("resume digit 0", {an1, dig1}, 8'he8);
    check("resume frame_done", {7'd0, fd1}, 8'h00);

    // Reset while digit 3 is lit.
    repeat (19) tick();
    check("digit 3 before reset", {an1, dig1}, 8'h75);
    rst_n = 1'b0;
    tick();
    check("mid-frame reset an_digit", {an1, dig1}, 8'hff);
    check("mid-frame reset frame_done", {7'd0, fd1}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("after mid-frame reset", {an1, dig1}, 8'he8);

    // No-dead-time instance.
    blank = 4'b0000; en = 1'b0; en0 = 1'b1;
    tick();
    check("idle after en drop", {an1, dig1}, 8'hff);
    run_frame(1'b1, 0, 16'h5678, 4'b0000, 1'b0, -1, 16'h0000);
    run_frame(1'b1, 0, 16'h5678, 4'b0000, 1'b1, -1, 16'h0000);

    en0 = 1'b0;
    tick();
    value = 16'h0070; en0 = 1'b1;
    tick();
`ifdef LEADING_ZERO_BLANK_EN
    run_frame(1'b1, 0, 16'h0070, 4'b1100, 1'b0, -1, 16'h0000);
`else
    run_frame(1'b1, 0, 16'h0070, 4'b0000, 1'b0, -1, 16'h0000);
`endif
    en0 = 1'b0;
    tick();
    value = 16'h0000; en0 = 1'b1;
    tick();
`ifdef LEADING_ZERO_BLANK_EN
    run_frame(1'b1, 0, 16'h0000, 4'b1110, 1'b0, -1, 16'h0000);
`else
    run_frame(1'b1, 0, 16'h0000, 4'b0000, 1'b0, -1, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svn_scan.md
Name: svn_scan

Overview:
Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It sits directly upstream of the seven-segment decoder and drives that decoder's 4-bit `in` input through its `digit` output. It also drives the four active-low anode enables.
- Display data is double-buffered per frame, so a digit never changes value mid-frame.
- A programmable dead time between digits suppresses ghosting.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit is lit in SHOW; legal range 2..2^20.
- DEAD_CYCLES, 0: clk cycles with all anodes off between digits; legal range 0..255; 0 means no GAP state.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous reset, active-low.
- en, input, 1: scan enable; 0 forces IDLE.
- value, input, 16: four BCD/hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- blank, input, 4: per-digit blank request; bit i blanks digit i.
- digit, output, 4: nibble to the seven-segment decoder; 4'hf means blank.
- AN, output, 4: anode enables, active-low; AN[i]=0 lights digit i.
- frame_done, output, 1: one-cycle pulse on completion of digit 3.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low; no asynchronous reset anywhere.
- Registers:
  - state: IDLE, SHOW, GAP.
  - idx: 2 bits.
  - cnt: 20 bits.
  - gcnt: 8 bits.
  - shadow value: 16 bits.
  - shadow blank: 4 bits.
  - frame_done: registered.
- Output decode: digit and AN are decoded combinationally from registered state only; there is no path from value, blank or en to the outputs.
- Reset (rst_n=0 at an edge):
  - state=IDLE, idx=0, cnt=0, gcnt=0.
  - shadow value=16'h0000, shadow blank=4'b1111.
  - frame_done=0.
  - Resulting outputs: AN=4'b1111, digit=4'hf.
- IDLE:
  - Outputs: AN=4'b1111, digit=4'hf.
  - Shadows load value and blank every cycle.
  - en=1 → SHOW with idx=0, cnt=0.
- SHOW:
  - If shadow blank[idx]=1: AN=4'b1111, digit=4'hf.
  - Otherwise: AN=~(4'b0001<<idx), digit=shadow value nibble[idx].
  - cnt increments each cycle.
  - At cnt==REFRESH_DIV-1: cnt←0. If DEAD_CYCLES>0, go to GAP with gcnt=0; otherwise advance (see below).
- GAP:
  - Outputs: AN=4'b1111, digit=4'hf.
  - gcnt increments each cycle.
  - At gcnt==DEAD_CYCLES-1: advance.
- Advance:
  - idx←idx+1, wrapping 3→0; state←SHOW.
  - When idx was 3: shadows load value/blank on that same edge, and frame_done=1 for exactly that following cycle.
- Timing:
  - Frame length = 4×(REFRESH_DIV+DEAD_CYCLES) cycles.
  - Input changes take effect at the next frame boundary, never mid-frame.
- en=0 in any state: next edge → IDLE; cnt, gcnt and idx clear; frame_done=0. Resume always starts at digit 0.
- rst_n=0 mid-frame or mid-GAP: identical to power-on reset; no partial digit completes and no frame_done pulse is produced.
- Priority: rst_n over en over scan progress.
- Sampling: value/blank are sampled only at the frame boundary or in IDLE; a simultaneous value change and frame boundary uses the value present at that edge.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: at every shadow load, the effective blank bit is OR-ed with a leading-zero mask. Digit i (i=3..1) is suppressed when its nibble and all more-significant nibbles are 4'h0. Digit 0 is never suppressed. Example: 16'h0070 gives effective blank 4'b1100.
- When undefined: shadow blank = blank input exactly, and zeros are displayed.

Test Plan (REFRESH_DIV=4, DEAD_CYCLES=2 unless noted):
- Reset check: rst_n=0 for 3 cycles with en=1 → AN=4'b1111, digit=4'hf, frame_done=0. After release, AN=4'b1110 and digit=4 on the first cycle with value=16'h1234.
- Full frame: value=16'h1234, blank=0 → per digit, 4 cycles SHOW then 2 cycles of AN=1111/digit=f. Sequence AN 1110/4, 1101/3, 1011/2, 0111/1. frame_done is a single pulse every 24 cycles.
- Frame buffering: change value to 16'h5678 during digit 1 → digits 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5.
- Blank and disable: blank=4'b0100 → digit 2 slot shows AN=1111/digit=f. Dropping en mid-GAP → IDLE next cycle. Re-raising en → restarts at AN=1110.
- DEAD_CYCLES=0: frame length 16 cycles, no all-off cycles between digits, idx wraps 3→0 with frame_done.
- LEADING_ZERO_BLANK_EN defined: value=16'h0070 → only digits 1 (7) and 0 (0) lit. value=16'h0000 → only digit 0 shows 0.
